// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: machine word and the MEM-stage controller states.
package cpu_types_pkg;

    localparam int WORD_BITS = 32;

    typedef logic [WORD_BITS-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } memstate_t;

endpackage

// File: rtl/mem_stage_if.sv
// MEM-stage bus: pipeline controls in, data-cache request out, result back to MEM/WB.
interface mem_stage_if #(
    parameter int WORD_W = 32
);
    logic              advance_i;
    logic              memren_i;
    logic              memwen_i;
    logic              ll_i;
    logic              sc_i;
    logic              halt_i;
    logic [WORD_W-1:0] addr_i;
    logic [WORD_W-1:0] store_i;
    logic              dhit_i;
    logic [WORD_W-1:0] dload_i;
    logic              ccinv_i;
    logic [WORD_W-1:0] ccaddr_i;
    logic              dmemREN_o;
    logic              dmemWEN_o;
    logic              datomic_o;
    logic [WORD_W-1:0] dmemaddr_o;
    logic [WORD_W-1:0] dmemstore_o;
    logic [WORD_W-1:0] dload_o;
    logic              mem_busy_o;
    logic              halted_o;

    modport slave (
        input  advance_i, memren_i, memwen_i, ll_i, sc_i, halt_i,
        input  addr_i, store_i, dhit_i, dload_i, ccinv_i, ccaddr_i,
        output dmemREN_o, dmemWEN_o, datomic_o, dmemaddr_o, dmemstore_o,
        output dload_o, mem_busy_o, halted_o
    );

    modport master (
        output advance_i, memren_i, memwen_i, ll_i, sc_i, halt_i,
        output addr_i, store_i, dhit_i, dload_i, ccinv_i, ccaddr_i,
        input  dmemREN_o, dmemWEN_o, datomic_o, dmemaddr_o, dmemstore_o,
        input  dload_o, mem_busy_o, halted_o
    );

endinterface

// File: rtl/llsc_link.sv
// LL/SC link register with address match and coherence invalidate.
// Only built when MEM_ATOMIC_EN is defined.
`ifdef MEM_ATOMIC_EN
module llsc_link #(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ll_done_i,
    input  logic              sc_done_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic              ccinv_i,
    input  logic [WORD_W-1:0] ccaddr_i,
    output logic              match_o
);

    logic              valid_q, valid_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic              inv_old, inv_new;

    assign inv_old = ccinv_i & (ccaddr_i == addr_q);
    assign inv_new = ccinv_i & (ccaddr_i == addr_i);

    // A snoop hitting the link this cycle already kills a pending SC.
    assign match_o = valid_q & (addr_q == addr_i) & ~inv_old;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (ll_done_i) begin
            valid_d = ~inv_new;
            addr_d  = addr_i;
        end else if (sc_done_i | inv_old) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

endmodule
`endif

// File: rtl/mem_stage.sv
// MEM-stage controller: holds the D-cache request until dhit, stalls, holds the result.
// Define MEM_ATOMIC_EN for LL/SC link tracking; otherwise LL/SC behave as LW/SW.
module mem_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = WORD_BITS
) (
    input logic       CLK,
    input logic       nRST,
    mem_stage_if.slave bus
);

    memstate_t         state_q, state_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic              halted_q, halted_d;

    logic              mem_op, is_load, is_store;
    logic              sc_fail, atomic_op;
    logic              ren, wen, complete;
    logic [WORD_W-1:0] result;

    // Requests are suppressed while reset is held so nothing leaks to the cache.
    assign mem_op   = (bus.memren_i | bus.memwen_i) & ~halted_q & nRST;
    assign is_load  = bus.memren_i;
    assign is_store = bus.memwen_i & ~bus.memren_i;

`ifdef MEM_ATOMIC_EN
    logic link_match;

    llsc_link #(.WORD_W(WORD_W)) u_link (
        .CLK       (CLK),
        .nRST      (nRST),
        .ll_done_i (complete & is_load & bus.ll_i),
        .sc_done_i (complete & is_store & bus.sc_i),
        .addr_i    (bus.addr_i),
        .ccinv_i   (bus.ccinv_i),
        .ccaddr_i  (bus.ccaddr_i),
        .match_o   (link_match)
    );

    assign sc_fail   = is_store & bus.sc_i & ~link_match;
    assign atomic_op = bus.ll_i | bus.sc_i;
`else
    logic unused_link;
    assign unused_link = ^{bus.ll_i, bus.ccinv_i, bus.ccaddr_i};
    assign sc_fail     = 1'b0;
    assign atomic_op   = 1'b0;
`endif

    assign result = (is_store & bus.sc_i) ? {{(WORD_W-1){1'b0}}, ~sc_fail} : bus.dload_i;

    // NOTE: every signal assigned here gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        halted_d = halted_q | (bus.halt_i & bus.advance_i);
        ren      = 1'b0;
        wen      = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            IDLE, REQ: begin
                if (mem_op) begin
                    ren      = is_load;
                    wen      = is_store & ~sc_fail;
                    complete = bus.dhit_i | sc_fail;
                    if (complete) begin
                        hold_d  = result;
                        state_d = bus.advance_i ? IDLE : DONE;
                    end else begin
                        state_d = REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (bus.advance_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            halted_q <= halted_d;
        end
    end

    assign bus.dmemREN_o   = ren;
    assign bus.dmemWEN_o   = wen;
    assign bus.datomic_o   = (ren | wen) & atomic_op;
    assign bus.dmemaddr_o  = (ren | wen) ? bus.addr_i : '0;
    assign bus.dmemstore_o = wen ? bus.store_i : '0;
    assign bus.dload_o     = complete ? result : ((state_q == DONE) ? hold_q : '0);
    assign bus.mem_busy_o  = mem_op & ~complete & (state_q != DONE);
    assign bus.halted_o    = halted_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; expectations adapt to MEM_ATOMIC_EN.
module tb_mem_stage;

`ifdef MEM_ATOMIC_EN
    localparam bit ATOMIC = 1'b1;
`else
    localparam bit ATOMIC = 1'b0;
`endif

    logic clk;
    logic nrst;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_stage_if #(.WORD_W(32)) bus ();

    mem_stage #(.WORD_W(32)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ops();
        bus.memren_i  = 1'b0;
        bus.memwen_i  = 1'b0;
        bus.ll_i      = 1'b0;
        bus.sc_i      = 1'b0;
        bus.halt_i    = 1'b0;
        bus.dhit_i    = 1'b0;
        bus.ccinv_i   = 1'b0;
        bus.advance_i = 1'b1;
    endtask

    int busy_cnt;
    int wen_cnt;

    initial begin
        nrst         = 1'b0;
        bus.addr_i   = '0;
        bus.store_i  = '0;
        bus.dload_i  = '0;
        bus.ccaddr_i = '0;
        clear_ops();
        tick();
        tick();
        check("rst_ren",    bus.dmemREN_o,  0);
        check("rst_busy",   bus.mem_busy_o, 0);
        check("rst_halted", bus.halted_o,   0);
        check("rst_dload",  bus.dload_o,    0);
        nrst = 1'b1;
        tick();

        // LW hit, zero latency
        bus.memren_i = 1'b1; bus.addr_i = 32'h100; bus.dload_i = 32'hDEADBEEF; bus.dhit_i = 1'b1;
        #1;
        check("lw_hit_ren",   bus.dmemREN_o,  1);
        check("lw_hit_addr",  bus.dmemaddr_o, 32'h100);
        check("lw_hit_busy",  bus.mem_busy_o, 0);
        check("lw_hit_dload", bus.dload_o,    32'hDEADBEEF);
        tick();
        clear_ops();
        #1;
        check("idle_ren",   bus.dmemREN_o,  0);
        check("idle_addr",  bus.dmemaddr_o, 0);
        check("idle_dload", bus.dload_o,    0);

        // SW with a 3-cycle miss
        busy_cnt = 0;
        wen_cnt  = 0;
        bus.memwen_i = 1'b1; bus.addr_i = 32'h200; bus.store_i = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            bus.dhit_i    = (i == 3);
            bus.advance_i = (i == 3);
            #1;
            if (i == 0) check("sw_store", bus.dmemstore_o, 32'h12345678);
            busy_cnt += int'(bus.mem_busy_o);
            wen_cnt  += int'(bus.dmemWEN_o);
            tick();
        end
        clear_ops();
        #1;
        wen_cnt += int'(bus.dmemWEN_o);
        check("sw_miss_busy_cycles", busy_cnt, 3);
        check("sw_miss_wen_cycles",  wen_cnt,  4);
        tick();

        // LW hit while the pipeline is stalled for 2 cycles
        bus.memren_i = 1'b1; bus.addr_i = 32'h104; bus.dload_i = 32'hCAFEF00D;
        bus.dhit_i = 1'b1; bus.advance_i = 1'b0;
        #1;
        check("stall_hit_dload", bus.dload_o,    32'hCAFEF00D);
        check("stall_hit_busy",  bus.mem_busy_o, 0);
        tick();
        bus.dhit_i = 1'b0; bus.dload_i = 32'hBAD0BAD0;
        #1;
        check("done_ren",   bus.dmemREN_o,  0);
        check("done_busy",  bus.mem_busy_o, 0);
        check("done_dload", bus.dload_o,    32'hCAFEF00D);
        tick();
        bus.advance_i = 1'b1;
        #1;
        check("done_adv_ren",   bus.dmemREN_o, 0);
        check("done_adv_dload", bus.dload_o,   32'hCAFEF00D);
        tick();
        clear_ops();
        #1;
        check("after_done_dload", bus.dload_o, 0);
        tick();

        // LL then two SCs to the same address
        bus.memren_i = 1'b1; bus.ll_i = 1'b1; bus.addr_i = 32'h300; bus.dload_i = 32'h55; bus.dhit_i = 1'b1;
        #1;
        check("ll_atomic", bus.datomic_o, 32'(ATOMIC));
        check("ll_dload",  bus.dload_o,   32'h55);
        tick();
        clear_ops();
        bus.memwen_i = 1'b1; bus.sc_i = 1'b1; bus.addr_i = 32'h300; bus.store_i = 32'hAA; bus.dhit_i = 1'b1;
        #1;
        check("sc1_wen",    bus.dmemWEN_o, 1);
        check("sc1_atomic", bus.datomic_o, 32'(ATOMIC));
        check("sc1_dload",  bus.dload_o,   1);
        tick();
        #1;
        check("sc2_wen",   bus.dmemWEN_o,  32'(!ATOMIC));
        check("sc2_dload", bus.dload_o,    32'(!ATOMIC));
        check("sc2_busy",  bus.mem_busy_o, 0);
        tick();
        clear_ops();

        // LL, invalidate, SC
        bus.memren_i = 1'b1; bus.ll_i = 1'b1; bus.addr_i = 32'h300; bus.dhit_i = 1'b1;
        tick();
        clear_ops();
        bus.ccinv_i = 1'b1; bus.ccaddr_i = 32'h300;
        tick();
        clear_ops();
        bus.memwen_i = 1'b1; bus.sc_i = 1'b1; bus.addr_i = 32'h300; bus.dhit_i = 1'b1;
        #1;
        check("sc_inv_wen",   bus.dmemWEN_o, 32'(!ATOMIC));
        check("sc_inv_dload", bus.dload_o,   32'(!ATOMIC));
        tick();
        clear_ops();

        // LL, SC misses, link invalidated while the SC waits
        bus.memren_i = 1'b1; bus.ll_i = 1'b1; bus.addr_i = 32'h300; bus.dhit_i = 1'b1;
        tick();
        clear_ops();
        bus.memwen_i = 1'b1; bus.sc_i = 1'b1; bus.addr_i = 32'h300; bus.advance_i = 1'b0;
        #1;
        check("sc_req_wen",  bus.dmemWEN_o,  1);
        check("sc_req_busy", bus.mem_busy_o, 1);
        tick();
        bus.ccinv_i = 1'b1; bus.ccaddr_i = 32'h300; bus.dhit_i = 1'b1; bus.advance_i = 1'b1;
        #1;
        check("sc_lost_wen",   bus.dmemWEN_o,  32'(!ATOMIC));
        check("sc_lost_dload", bus.dload_o,    32'(!ATOMIC));
        check("sc_lost_busy",  bus.mem_busy_o, 0);
        tick();
        clear_ops();

        // Reset in the middle of a missing load
        bus.memren_i = 1'b1; bus.addr_i = 32'h400; bus.advance_i = 1'b0;
        #1;
        check("pre_rst_busy", bus.mem_busy_o, 1);
        tick();
        #2;
        nrst = 1'b0;
        #1;
        check("midrst_ren",   bus.dmemREN_o,  0);
        check("midrst_busy",  bus.mem_busy_o, 0);
        check("midrst_addr",  bus.dmemaddr_o, 0);
        check("midrst_dload", bus.dload_o,    0);
        clear_ops();
        tick();
        nrst = 1'b1;
        #1;
        check("postrst_ren",    bus.dmemREN_o, 0);
        check("postrst_halted", bus.halted_o,  0);
        tick();

        // Halt with advance, then later ops are blocked
        bus.halt_i = 1'b1;
        tick();
        clear_ops();
        #1;
        check("halted_set", bus.halted_o, 1);
        bus.memren_i = 1'b1; bus.addr_i = 32'h500;
        #1;
        check("halted_ren",  bus.dmemREN_o,  0);
        check("halted_busy", bus.mem_busy_o, 0);
        tick();
        clear_ops();
        bus.memwen_i = 1'b1; bus.addr_i = 32'h504;
        #1;
        check("halted_wen",    bus.dmemWEN_o, 0);
        check("halted_sticky", bus.halted_o,  1);
        tick();
        clear_ops();
        nrst = 1'b0;
        #1;
        check("halt_cleared", bus.halted_o, 0);
        nrst = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
